// File: rtl/fft_pkg.sv
// fft_pkg: shared constants for the FFT twiddle multiplier slice.
//   DEF_DATA_WIDTH / DEF_TW_WIDTH / DEF_TW_FRAC : default parameter values
//   ROUND_CONST                                 : round-half-up bias for DEF_TW_FRAC
//   PROD_WIDTH / SUM_WIDTH                      : default product / sum widths
//   TW_IDX_WIDTH                                : twiddle index width (8 twiddles)
package fft_pkg;
   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_TW_WIDTH   = 8;
   localparam int DEF_TW_FRAC    = 7;
   localparam int ROUND_CONST    = 1 << (DEF_TW_FRAC - 1);
   localparam int PROD_WIDTH     = DEF_DATA_WIDTH + DEF_TW_WIDTH;
   localparam int SUM_WIDTH      = PROD_WIDTH + 1;
   localparam int TW_IDX_WIDTH   = 3;
endpackage

// File: rtl/twiddle_cmul_if.sv
// twiddle_cmul_if: sample-in / product-out streams of the twiddle multiplier.
//   in_i, in_q, in_tw_idx, in_valid / in_ready : butterfly sample input
//   out_i, out_q, out_valid / out_ready        : rounded product output
//   modport slave  : the multiplier's view
//   modport master : the producer/consumer environment's view
interface twiddle_cmul_if
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic signed [DATA_WIDTH-1:0]   in_i;
   logic signed [DATA_WIDTH-1:0]   in_q;
   logic        [TW_IDX_WIDTH-1:0] in_tw_idx;
   logic                           in_valid;
   logic                           in_ready;
   logic signed [DATA_WIDTH-1:0]   out_i;
   logic signed [DATA_WIDTH-1:0]   out_q;
   logic                           out_valid;
   logic                           out_ready;

   modport slave (
      input  in_i, in_q, in_tw_idx, in_valid, out_ready,
      output in_ready, out_i, out_q, out_valid
   );

   modport master (
      output in_i, in_q, in_tw_idx, in_valid, out_ready,
      input  in_ready, out_i, out_q, out_valid
   );
endinterface

// File: rtl/twiddle_cmul_round_sat.sv
// round_sat: combinational round-half-up, arithmetic right shift by FRAC and
// saturation of a wide signed sum to OUT_WIDTH bits.
//   sum_in  : signed IN_WIDTH sum of products
//   sat_out : signed OUT_WIDTH rounded, saturated result
module round_sat
   import fft_pkg::*;
#(
   parameter int IN_WIDTH  = SUM_WIDTH,
   parameter int OUT_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC      = DEF_TW_FRAC
) (
   input  logic signed [IN_WIDTH-1:0]  sum_in,
   output logic signed [OUT_WIDTH-1:0] sat_out
);
   localparam logic signed [IN_WIDTH-1:0] RND     = IN_WIDTH'(1) << (FRAC - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX = (IN_WIDTH'(1) << (OUT_WIDTH - 1)) - IN_WIDTH'(1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -(IN_WIDTH'(1) << (OUT_WIDTH - 1));

   logic signed [IN_WIDTH-1:0] rounded;
   logic signed [IN_WIDTH-1:0] shifted;

   always_comb begin
      // The sum carries at least one spare sign bit, so adding the bias cannot wrap.
      rounded = sum_in + RND;
      shifted = rounded >>> FRAC;
      if (shifted > SAT_MAX) begin
         sat_out = SAT_MAX[OUT_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_out = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         sat_out = shifted[OUT_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/twiddle_cmul.sv
// twiddle_cmul: three-stage pipelined complex multiplier behind the 16-point
// FFT twiddle ROM. Computes round_sat(sample * W[idx]) with valid/ready on
// both sides and a single global enable.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : sample input stream and product output stream
//   tw_addr         : ROM address (combinational)
//   tw_i, tw_q      : ROM registered twiddle, valid one cycle after tw_addr
// Optional build macro TWIDDLE_UNITY_BYPASS_EN: samples with index 0 pass
// through unchanged instead of being scaled by 127/128.
module twiddle_cmul
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TW_WIDTH   = DEF_TW_WIDTH,
   parameter int TW_FRAC    = DEF_TW_FRAC
) (
   input  logic                        clk,
   input  logic                        rst,
   twiddle_cmul_if.slave               bus,
   output logic [TW_IDX_WIDTH-1:0]     tw_addr,
   input  logic signed [TW_WIDTH-1:0]  tw_i,
   input  logic signed [TW_WIDTH-1:0]  tw_q
);
   localparam int PROD_W = DATA_WIDTH + TW_WIDTH;
   localparam int SUM_W  = PROD_W + 1;

   logic en;
   logic accept;

   // S1: sample registers, aligned with the ROM output one cycle later
   logic signed [DATA_WIDTH-1:0]   s1_ar_d, s1_ar_q;
   logic signed [DATA_WIDTH-1:0]   s1_ai_d, s1_ai_q;
   logic        [TW_IDX_WIDTH-1:0] s1_idx_d, s1_idx_q;
   logic                           v1_d, v1_q;

   // S2: partial products
   logic signed [PROD_W-1:0] p_rr_d, p_rr_q;   // ar*wr
   logic signed [PROD_W-1:0] p_ii_d, p_ii_q;   // ai*wi
   logic signed [PROD_W-1:0] p_ri_d, p_ri_q;   // ar*wi
   logic signed [PROD_W-1:0] p_ir_d, p_ir_q;   // ai*wr
   logic                     v2_d, v2_q;

   // S3: output registers
   logic signed [SUM_W-1:0]      re_sum, im_sum;
   logic signed [DATA_WIDTH-1:0] re_sat, im_sat;
   logic signed [DATA_WIDTH-1:0] out_i_d, out_i_q;
   logic signed [DATA_WIDTH-1:0] out_q_d, out_q_q;
   logic                         out_valid_d, out_valid_q;

`ifdef TWIDDLE_UNITY_BYPASS_EN
   logic                         byp2_d, byp2_q;
   logic signed [DATA_WIDTH-1:0] s2_ar_d, s2_ar_q;
   logic signed [DATA_WIDTH-1:0] s2_ai_d, s2_ai_q;
`endif

   // Whole pipeline advances together whenever the output slot is free.
   assign en           = !out_valid_q || bus.out_ready;
   assign bus.in_ready = en && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   // While not accepting, re-present the S1 index so the ROM keeps
   // returning the twiddle that belongs to the sample held in S1.
   assign tw_addr = accept ? bus.in_tw_idx : s1_idx_q;

   assign bus.out_i     = out_i_q;
   assign bus.out_q     = out_q_q;
   assign bus.out_valid = out_valid_q;

   // S1
   always_comb begin
      s1_ar_d  = s1_ar_q;
      s1_ai_d  = s1_ai_q;
      s1_idx_d = s1_idx_q;
      v1_d     = v1_q;
      if (accept) begin
         s1_ar_d  = bus.in_i;
         s1_ai_d  = bus.in_q;
         s1_idx_d = bus.in_tw_idx;
      end
      if (en) begin
         v1_d = accept;   // an idle enabled cycle inserts a bubble
      end
   end

   // S2
   always_comb begin
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ri_d = p_ri_q;
      p_ir_d = p_ir_q;
      v2_d   = v2_q;
      if (en) begin
         p_rr_d = PROD_W'(s1_ar_q) * PROD_W'(tw_i);
         p_ii_d = PROD_W'(s1_ai_q) * PROD_W'(tw_q);
         p_ri_d = PROD_W'(s1_ar_q) * PROD_W'(tw_q);
         p_ir_d = PROD_W'(s1_ai_q) * PROD_W'(tw_i);
         v2_d   = v1_q;
      end
   end

`ifdef TWIDDLE_UNITY_BYPASS_EN
   always_comb begin
      byp2_d  = byp2_q;
      s2_ar_d = s2_ar_q;
      s2_ai_d = s2_ai_q;
      if (en) begin
         byp2_d  = (s1_idx_q == '0);
         s2_ar_d = s1_ar_q;
         s2_ai_d = s1_ai_q;
      end
   end
`endif

   // S3
   always_comb begin
      re_sum = SUM_W'(p_rr_q) - SUM_W'(p_ii_q);
      im_sum = SUM_W'(p_ri_q) + SUM_W'(p_ir_q);
   end

   round_sat #(
      .IN_WIDTH  (SUM_W),
      .OUT_WIDTH (DATA_WIDTH),
      .FRAC      (TW_FRAC)
   ) u_round_re (
      .sum_in  (re_sum),
      .sat_out (re_sat)
   );

   round_sat #(
      .IN_WIDTH  (SUM_W),
      .OUT_WIDTH (DATA_WIDTH),
      .FRAC      (TW_FRAC)
   ) u_round_im (
      .sum_in  (im_sum),
      .sat_out (im_sat)
   );

   always_comb begin
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      out_valid_d = out_valid_q;
      if (en) begin
`ifdef TWIDDLE_UNITY_BYPASS_EN
         if (byp2_q) begin
            out_i_d = s2_ar_q;
            out_q_d = s2_ai_q;
         end else begin
            out_i_d = re_sat;
            out_q_d = im_sat;
         end
`else
         out_i_d = re_sat;
         out_q_d = im_sat;
`endif
         out_valid_d = v2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_ar_q     <= '0;
         s1_ai_q     <= '0;
         s1_idx_q    <= '0;
         v1_q        <= 1'b0;
         p_rr_q      <= '0;
         p_ii_q      <= '0;
         p_ri_q      <= '0;
         p_ir_q      <= '0;
         v2_q        <= 1'b0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s1_ar_q     <= s1_ar_d;
         s1_ai_q     <= s1_ai_d;
         s1_idx_q    <= s1_idx_d;
         v1_q        <= v1_d;
         p_rr_q      <= p_rr_d;
         p_ii_q      <= p_ii_d;
         p_ri_q      <= p_ri_d;
         p_ir_q      <= p_ir_d;
         v2_q        <= v2_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef TWIDDLE_UNITY_BYPASS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byp2_q  <= 1'b0;
         s2_ar_q <= '0;
         s2_ai_q <= '0;
      end else begin
         byp2_q  <= byp2_d;
         s2_ar_q <= s2_ar_d;
         s2_ai_q <= s2_ai_d;
      end
   end
`endif
endmodule

// File: doc/twiddle_cmul.md
Name: twiddle_cmul

Overview:
- Pipelined complex multiplier directly downstream of the 16-point FFT twiddle ROM.
- Accepts a butterfly-output sample tagged with a 3-bit twiddle index.
- Drives the ROM address and aligns the sample with the ROM's registered twiddle output.
- Produces the rounded, saturated product sample*W; valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 12, width of signed I/Q data in and out.
- TW_WIDTH, 8, width of signed twiddle I/Q (Q1.7); must equal the ROM word length.
- TW_FRAC, 7, twiddle fractional bits; product shift amount.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_i  in  DATA_WIDTH  sample real part, signed.
- in_q  in  DATA_WIDTH  sample imaginary part, signed.
- in_tw_idx  in  3  twiddle index of the sample.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts the sample this cycle.
- tw_addr  out  3  ROM address, combinational.
- tw_i  in  TW_WIDTH  ROM registered real twiddle.
- tw_q  in  TW_WIDTH  ROM registered imaginary twiddle.
- out_i  out  DATA_WIDTH  product real part.
- out_q  out  DATA_WIDTH  product imaginary part.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts.

Behaviour:
- Global enable: en = !out_valid || out_ready. in_ready = en && !rst. accept = in_valid && in_ready.
- tw_addr = accept ? in_tw_idx : s1_idx. The ROM recaptures the same twiddle while stalled, so S1 data and tw_i/tw_q stay aligned.
- S1 (on accept): register in_i, in_q, idx, v1. One cycle later tw_i/tw_q belong to this sample.
- S2 (en): register the four products ar*wr, ai*wi, ar*wi, ai*wr, each DATA_WIDTH+TW_WIDTH bits; register v2 <= v1.
- S3 (en): re = ar*wr - ai*wi; im = ar*wi + ai*wr, each computed at DATA_WIDTH+TW_WIDTH+1 bits.
  - Round: (x + 2^(TW_FRAC-1)) >>> TW_FRAC, arithmetic shift (round half up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register to out_i/out_q; out_valid <= v2.
- When en is 0, all stage registers, valids and out_* hold.
- A bubble (v1=0) still advances, clearing valid downstream.
- Latency: accept edge to out_valid = 3 clk with no stall. Throughput is 1 sample/clk.
- Reset (any time, including mid-pipeline): all valids=0, out_i=out_q=0, stage data=0, s1_idx=0, in_ready=0 while rst=1. The first accept is possible on the first cycle after release.
- Index 4 (W=-j, twiddle value -128 exact): result is (ai, -ar). The single overflow case ar=-2048 saturates im to 2047.
- Index 0 (twiddle 127/128): result is scaled by 127/128 with rounding; no special-casing.

Optional Feature:
- Macro TWIDDLE_UNITY_BYPASS_EN.
- Defined: when the S1 sample has idx==0, S3 outputs ar/ai exactly (unity), bypassing multiply, round and saturate. Latency is unchanged; the bypass flag is pipelined alongside v2.
- Undefined: index 0 is multiplied like any other index.

Decomposition:
- Package fft_pkg holds DATA_WIDTH, TW_WIDTH, TW_FRAC defaults, ROUND_CONST = 2^(TW_FRAC-1), and the product/sum width localparams.
- One sub-module, round_sat: combinational round-half-up, arithmetic shift and saturation from the wide sum to DATA_WIDTH.
- Instantiate round_sat twice (re, im).

Test Plan:
- Normal product: accept (100, 0) idx=2; ROM model gives (91, -91) -> 3 clk later out=(71, -71), out_valid=1.
- Index 0 scaling: accept (1000, 0) idx=0 -> out=(992, 0) without macro; (1000, 0) with TWIDDLE_UNITY_BYPASS_EN.
- Saturation: accept (-2048, 5) idx=4 -> out=(5, 2047).
- Backpressure:
  - Stimulus: stream idx 0..7 back-to-back; hold out_ready=0 for 4 cycles mid-stream.
  - Required: in_ready=0 during the stall; tw_addr holds s1_idx; no loss or duplication; outputs match the golden model in order.
- Reset mid-operation: rst=1 with 3 samples in flight -> out_valid=0 and out=0 immediately (async); after release, the next sample emerges after 3 clk with no stale data.
